// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// register-file constants and the NOP bubble loaded by flushed registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_ST_RUN      = 2'd0,
    PC_ST_LD_BUB   = 2'd1,
    PC_ST_MEM_WAIT = 2'd2
  } pc_state_e;

  localparam logic [4:0]  ZERO_REG = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard compare between the ID-stage source registers and the
// destination of a load sitting in EX. Purely combinational.
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_rd_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_re_i,
  input  logic       id_rs2_re_i,
  output logic       hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_re_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit  = id_rs2_re_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign hazard_o = ex_mem_rd_i & (ex_rd_addr_i != ZERO_REG) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: arbitrates bus waits, EX redirects and
// load-use bubbles, with a bus-wait watchdog. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_re_i,
  input  logic            id_rs2_re_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_mem_rd_i,
  input  logic            mem_req_i,
  input  logic            mem_ack_i,
  output logic            pc_jump_en_o,
  output logic [XLEN-1:0] pc_jump_addr_o,
  output logic            hold_pc_o,
  output logic            hold_if_id_o,
  output logic            hold_id_ex_o,
  output logic            flush_if_id_o,
  output logic            flush_id_ex_o,
  output logic            bus_err_o,
  output logic [1:0]      state_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  pc_state_e  state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic hazard, bus_wait, in_run, evaluate, do_jump, do_haz, timeout_hit, abort;

  pipe_ctrl_hazard u_hazard (
    .ex_mem_rd_i   (ex_mem_rd_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_re_i   (id_rs1_re_i),
    .id_rs2_re_i   (id_rs2_re_i),
    .hazard_o      (hazard)
  );

  // An acked MEM_WAIT cycle is judged exactly like RUN (hazard unmasked).
  assign bus_wait    = mem_req_i & ~mem_ack_i;
  assign in_run      = (state_q == PC_ST_RUN) | (state_q == PC_ST_LD_BUB);
  assign evaluate    = (in_run & ~bus_wait) | ((state_q == PC_ST_MEM_WAIT) & mem_ack_i);
  assign do_jump     = evaluate & jump_en_i;
  assign do_haz      = evaluate & ~jump_en_i & hazard & (state_q != PC_ST_LD_BUB);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC));
  assign abort       = (state_q == PC_ST_MEM_WAIT) & ~mem_ack_i & timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_run && bus_wait)
        wait_cnt_q <= CNT_W'(1);
      else if (state_q == PC_ST_MEM_WAIT && !mem_ack_i && !abort)
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else
        wait_cnt_q <= '0;
    end
  end

  always_comb begin
    state_d = PC_ST_RUN;
    case (state_q)
      PC_ST_RUN, PC_ST_LD_BUB: begin
        if (bus_wait)    state_d = PC_ST_MEM_WAIT;
        else if (do_haz) state_d = PC_ST_LD_BUB;
      end
      PC_ST_MEM_WAIT: begin
        if (mem_ack_i)   state_d = do_haz ? PC_ST_LD_BUB : PC_ST_RUN;
        else if (!abort) state_d = PC_ST_MEM_WAIT;
      end
      default: state_d = PC_ST_RUN;
    endcase
  end

  always_comb begin
    pc_jump_en_o   = 1'b0;
    pc_jump_addr_o = '0;
    hold_pc_o      = 1'b0;
    hold_if_id_o   = 1'b0;
    hold_id_ex_o   = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    bus_err_o      = 1'b0;
    state_o        = state_q;
    if (!rst_n) begin
      state_o = '0;
    end else if ((in_run && bus_wait) ||
                 (state_q == PC_ST_MEM_WAIT && !mem_ack_i && !abort)) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (abort) begin
      bus_err_o     = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (do_jump) begin
      pc_jump_en_o   = 1'b1;
      pc_jump_addr_o = jump_addr_i;
      flush_if_id_o  = 1'b1;
      flush_id_ex_o  = 1'b1;
    end else if (do_haz) begin
      hold_pc_o     = 1'b1;
      hold_if_id_o  = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, hold_pc_o};
      flush_cnt_q <= flush_cnt_q + {31'd0, pc_jump_en_o};
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them. Two instances: watchdog 4 and disabled.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_re, rs2_re, ex_mem_rd, mem_req, mem_ack;

  logic        a_jen, a_hpc, a_hif, a_hid, a_fif, a_fid, a_berr;
  logic [31:0] a_jaddr, a_stall, a_flush;
  logic [1:0]  a_st;
  logic        b_jen, b_hpc, b_hif, b_hid, b_fif, b_fid, b_berr;
  logic [31:0] b_jaddr, b_stall, b_flush;
  logic [1:0]  b_st;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT_CYC(4), .XLEN(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr), .id_rs1_re_i(rs1_re),
    .id_rs2_re_i(rs2_re), .ex_rd_addr_i(rd_addr), .ex_mem_rd_i(ex_mem_rd),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack), .pc_jump_en_o(a_jen),
    .pc_jump_addr_o(a_jaddr), .hold_pc_o(a_hpc), .hold_if_id_o(a_hif),
    .hold_id_ex_o(a_hid), .flush_if_id_o(a_fif), .flush_id_ex_o(a_fid),
    .bus_err_o(a_berr), .state_o(a_st), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipe_ctrl #(.TIMEOUT_CYC(0), .XLEN(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr), .id_rs1_re_i(rs1_re),
    .id_rs2_re_i(rs2_re), .ex_rd_addr_i(rd_addr), .ex_mem_rd_i(ex_mem_rd),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack), .pc_jump_en_o(b_jen),
    .pc_jump_addr_o(b_jaddr), .hold_pc_o(b_hpc), .hold_if_id_o(b_hif),
    .hold_id_ex_o(b_hid), .flush_if_id_o(b_fif), .flush_id_ex_o(b_fid),
    .bus_err_o(b_berr), .state_o(b_st), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  typedef struct {
    int          kind;   // 0: dut A outputs, 1: dut B outputs, 2: dut A perf counters
    logic [63:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] ov(input logic jen, input logic [31:0] addr,
                                     input logic hpc, input logic hif, input logic hid,
                                     input logic fif, input logic fid, input logic berr,
                                     input logic [1:0] st);
    return {23'd0, jen, addr, hpc, hif, hid, fif, fid, berr, st};
  endfunction

  // Monitor: compares every queued expectation against the DUT at the negedge.
  exp_t        mon_e;
  logic [63:0] act;
  always @(negedge clk) begin
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        0:       act = ov(a_jen, a_jaddr, a_hpc, a_hif, a_hid, a_fif, a_fid, a_berr, a_st);
        1:       act = ov(b_jen, b_jaddr, b_hpc, b_hif, b_hid, b_fif, b_fid, b_berr, b_st);
        default: act = {a_stall, a_flush};
      endcase
      n_vec++;
      if (act !== mon_e.v) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", mon_e.name, act, mon_e.v);
      end
    end
  end

  task automatic set_in(input logic jen, input logic [31:0] jaddr, input logic mreq,
                        input logic mack, input logic emr, input logic [4:0] rd,
                        input logic r1re, input logic [4:0] r1, input logic r2re,
                        input logic [4:0] r2);
    jump_en = jen; jump_addr = jaddr; mem_req = mreq; mem_ack = mack;
    ex_mem_rd = emr; rd_addr = rd; rs1_re = r1re; rs1_addr = r1;
    rs2_re = r2re; rs2_addr = r2;
  endtask

  task automatic idle();
    set_in(0, 32'h0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic haz();
    set_in(0, 32'h0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
  endtask

  // Queue an expectation for the current cycle, then advance to just past the next edge.
  task automatic chk(input int kind, input string name, input logic [63:0] v);
    exp_t e;
    e.kind = kind; e.v = v; e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] ZERO = 64'd0;

  initial begin
    idle();
    @(posedge clk); #1;
    // Reset: all outputs low regardless of inputs
    set_in(1, 32'hDEAD_BEEF, 1, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    chk(0, "reset_outs", ZERO);
    chk(0, "reset_outs2", ZERO);
    rst_n = 1'b1;
    idle();
    chk(0, "idle_run", ZERO);

    // Load-use on rs1: stall, one masked bubble, back to RUN
    haz();  chk(0, "lu_stall",  ov(0, 0, 1, 1, 0, 0, 1, 0, 2'd0));
    haz();  chk(0, "lu_bubble", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    idle(); chk(0, "lu_back",   ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    // rd = x0 never stalls
    set_in(0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0);
    chk(0, "lu_rd0", ZERO);
    // rs2 path
    set_in(0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 1, 5'd7);
    chk(0, "lu_rs2", ov(0, 0, 1, 1, 0, 0, 1, 0, 2'd0));
    idle(); chk(0, "lu_rs2_bub", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    // Non-load in EX never stalls
    set_in(0, 0, 0, 0, 0, 5'd5, 1, 5'd5, 0, 5'd0);
    chk(0, "no_load", ZERO);

    // Jump overrides hazard
    set_in(1, 32'h0000_0100, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    chk(0, "jump_haz", ov(1, 32'h100, 0, 0, 0, 1, 1, 0, 2'd0));
    idle(); chk(0, "jump_after", ZERO);
    // Jump during the bubble cycle
    haz(); chk(0, "bub_stall", ov(0, 0, 1, 1, 0, 0, 1, 0, 2'd0));
    set_in(1, 32'h0000_0200, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    chk(0, "bub_jump", ov(1, 32'h200, 0, 0, 0, 1, 1, 0, 2'd1));
    idle(); chk(0, "bub_jump_after", ZERO);

    // Bus wait, ack on cycle 4; jump raised at cycle 2 only acts at ack
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "bw_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    chk(0, "bw_c1", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    set_in(1, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "bw_c2_jump", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    chk(0, "bw_c3_jump", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    set_in(1, 32'h0000_0300, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(0, "bw_c4_ack", ov(1, 32'h300, 0, 0, 0, 1, 1, 0, 2'd2));
    idle(); chk(0, "bw_after", ZERO);

    // Request and ack in the same cycle: no stall
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(0, "req_ack", ZERO);
    idle(); chk(0, "req_ack_after", ZERO);

    // Bus wait in the bubble cycle
    haz(); chk(0, "bwb_stall", ov(0, 0, 1, 1, 0, 0, 1, 0, 2'd0));
    set_in(0, 0, 1, 0, 1, 5'd5, 1, 5'd5, 0, 0);
    chk(0, "bwb_wait", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd1));
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(0, "bwb_ack", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd2));
    idle(); chk(0, "bwb_after", ZERO);

    // Bus wait beats jump; ack with a hazard bubbles from MEM_WAIT
    set_in(1, 32'h0000_0440, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "bw_over_jump", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    set_in(0, 0, 1, 1, 1, 5'd9, 0, 0, 1, 5'd9);
    chk(0, "ack_haz", ov(0, 0, 1, 1, 0, 0, 1, 0, 2'd2));
    idle(); chk(0, "ack_haz_bub", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    idle(); chk(0, "ack_haz_run", ZERO);

    // Watchdog (TIMEOUT_CYC=4): abort in the 5th cycle
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "wd_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    for (int unsigned i = 1; i < 4; i++)
      chk(0, $sformatf("wd_c%0d", i), ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    idle();
    chk(0, "wd_abort", ov(0, 0, 0, 0, 0, 0, 1, 1, 2'd2));
    chk(0, "wd_after", ZERO);

    // Release instance B, then hold it 100 cycles with the watchdog disabled
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(1, "b_release", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd2));
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(1, "b_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    for (int unsigned i = 1; i <= 100; i++)
      chk(1, $sformatf("b_c%0d", i), ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(1, "b_ack", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd2));
    idle(); chk(1, "b_after", ZERO);

    // Reset in the middle of a bus wait
    set_in(1, 32'h0000_0500, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "mr_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    chk(0, "mr_c1", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    rst_n = 1'b0;
    chk(0, "mr_reset", ZERO);
    chk(0, "mr_reset2", ZERO);
    rst_n = 1'b1;
    idle(); chk(0, "mr_after", ZERO);

    // 3-cycle wait then one jump for the perf counters
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "pf_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    chk(0, "pf_c1", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    chk(0, "pf_c2", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk(0, "pf_ack", ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd2));
    set_in(1, 32'h0000_0400, 0, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "pf_jump", ov(1, 32'h400, 0, 0, 0, 1, 1, 0, 2'd0));
    idle();
`ifdef PIPE_CTRL_PERF_EN
    chk(2, "perf_cnt", {32'd3, 32'd1});
`else
    chk(2, "perf_cnt", 64'd0);
`endif

    // Watchdog still aborts in the 5th cycle after the reset
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "wd2_c0", ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    for (int unsigned i = 1; i < 4; i++)
      chk(0, $sformatf("wd2_c%0d", i), ov(0, 0, 1, 1, 1, 0, 0, 0, 2'd2));
    idle();
    chk(0, "wd2_abort", ov(0, 0, 0, 0, 0, 0, 1, 1, 2'd2));
    chk(0, "wd2_after", ZERO);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
